// File: rtl/lfsr_checker.sv
// lfsr_checker
//   Tracks a received 4-bit LFSR state stream, predicted by
//   nxt(s) = {s[2:0], s[3]^s[0]} (period 15; 0000 is the lock-up state).
//   SEARCH waits for a nonzero seed sample. VERIFY needs LOCK_CNT consecutive
//   correct predictions before it declares lock. LOCKED flywheels on its own
//   prediction, counts mispredictions, and drops lock after UNLOCK_ERRS
//   consecutive ones.
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous reset, active-high
//   in_valid   in_data carries a sample this cycle
//   in_data    received LFSR state sample (4 bits)
//   err_clr    synchronous clear of err_count
//   locked     1 while in LOCKED
//   err_pulse  one-cycle flag: last accepted LOCKED sample mispredicted
//   err_count  saturating count of LOCKED mispredictions (8 bits)
//   state_out  FSM state: 00 SEARCH, 01 VERIFY, 10 LOCKED
module lfsr_checker #(
  parameter int LOCK_CNT    = 4,
  parameter int UNLOCK_ERRS = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [3:0] in_data,
  input  logic       err_clr,
  output logic       locked,
  output logic       err_pulse,
  output logic [7:0] err_count,
  output logic [1:0] state_out
);

  typedef enum logic [1:0] {
    SEARCH = 2'b00,
    VERIFY = 2'b01,
    LOCKED = 2'b10
  } state_t;

  localparam logic [3:0] LOCK_TGT   = 4'(LOCK_CNT);
  localparam logic [3:0] UNLOCK_TGT = 4'(UNLOCK_ERRS);

  function automatic logic [3:0] lfsr_nxt(input logic [3:0] s);
    return {s[2:0], s[3] ^ s[0]};
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  state_t     state_q,    state_nxt;
  logic [3:0] expected_q, expected_nxt;
  logic [3:0] good_cnt_q, good_cnt_nxt;
  logic [3:0] bad_run_q,  bad_run_nxt;
  logic [7:0] err_cnt_q,  err_cnt_nxt;
  logic       err_pls_q,  err_pls_nxt;
  logic       locked_q;
  logic       miss;

  // Next-state decode: everything holds unless a sample is accepted.
  always_comb begin
    state_nxt    = state_q;
    expected_nxt = expected_q;
    good_cnt_nxt = good_cnt_q;
    bad_run_nxt  = bad_run_q;
    err_pls_nxt  = 1'b0;
    miss         = 1'b0;

    if (in_valid) begin
      case (state_q)
        SEARCH: begin
          if (in_data != 4'b0000) begin
            expected_nxt = lfsr_nxt(in_data);
            good_cnt_nxt = 4'd0;
            state_nxt    = VERIFY;
          end
        end
        VERIFY: begin
          if (in_data == expected_q) begin
            good_cnt_nxt = good_cnt_q + 4'd1;
            expected_nxt = lfsr_nxt(in_data);
            if (good_cnt_q + 4'd1 == LOCK_TGT) state_nxt = LOCKED;
          end else if (in_data != 4'b0000) begin
            // Re-seed from the offending sample rather than giving up.
            good_cnt_nxt = 4'd0;
            expected_nxt = lfsr_nxt(in_data);
          end else begin
            state_nxt = SEARCH;
          end
        end
        LOCKED: begin
          // Flywheel: the prediction advances from itself, never from the sample.
          expected_nxt = lfsr_nxt(expected_q);
          if (in_data == expected_q) begin
            bad_run_nxt = 4'd0;
          end else begin
            miss        = 1'b1;
            err_pls_nxt = 1'b1;
            if (bad_run_q + 4'd1 == UNLOCK_TGT) begin
              bad_run_nxt = 4'd0;
              state_nxt   = SEARCH;
            end else begin
              bad_run_nxt = bad_run_q + 4'd1;
            end
          end
        end
        default: state_nxt = SEARCH;
      endcase
    end

    // Clear wins over the old count, but an error in the same cycle still counts.
    if (err_clr)   err_cnt_nxt = miss ? 8'd1 : 8'd0;
    else if (miss) err_cnt_nxt = sat_inc(err_cnt_q);
    else           err_cnt_nxt = err_cnt_q;
  end

  // State register stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= SEARCH;
      expected_q <= 4'b1111;
      good_cnt_q <= 4'd0;
      bad_run_q  <= 4'd0;
      err_cnt_q  <= 8'd0;
      err_pls_q  <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_nxt;
      expected_q <= expected_nxt;
      good_cnt_q <= good_cnt_nxt;
      bad_run_q  <= bad_run_nxt;
      err_cnt_q  <= err_cnt_nxt;
      err_pls_q  <= err_pls_nxt;
      locked_q   <= (state_nxt == LOCKED);
    end
  end

  assign locked    = locked_q;
  assign err_pulse = err_pls_q;
  assign err_count = err_cnt_q;
  assign state_out = state_q;

endmodule
